// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N_CH-input valid/ready stream multiplexer feeding a
// single-entry output register. Mode 0 arbitrates round-robin starting
// after the last granted channel; mode 1 forces the channel given by sel.
// Only mode-0 transfers advance the round-robin pointer, so a detour into
// forced select resumes fairness where it left off.
module stream_mux_rr #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [$clog2(N_CH)-1:0]   sel,
  input  logic [N_CH-1:0]           in_valid,
  input  logic [N_CH*DATA_W-1:0]    in_data,
  output logic [N_CH-1:0]           in_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [$clog2(N_CH)-1:0]   out_ch,
  input  logic                      out_ready
);

  localparam int SEL_W = $clog2(N_CH);

  // Unpacked view of the per-channel data words
  logic [DATA_W-1:0] ch_data [N_CH];

  // Output register and round-robin pointer
  logic                 out_valid_reg, out_valid_next;
  logic [DATA_W-1:0]    out_data_reg,  out_data_next;
  logic [SEL_W-1:0]     out_ch_reg,    out_ch_next;
  logic [SEL_W-1:0]     last_grant_reg, last_grant_next;

  // Arbitration results
  logic                 load_en;
  logic                 rr_found;
  logic [SEL_W-1:0]     rr_idx;
  logic                 fs_found;
  logic                 grant_found;
  logic [SEL_W-1:0]     grant_idx;
  logic                 xfer;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_unpack
      assign ch_data[gi] = in_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // The output slot can take a new word when empty or being drained now
  assign load_en = ~out_valid_reg | out_ready;

  // Round-robin search: the candidate at the smallest offset past
  // last_grant wins, so scan from the farthest offset down and let the
  // nearest valid channel overwrite earlier hits.
  always_comb begin : rr_search
    int               cand;
    logic [SEL_W-1:0] cand_idx;
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = N_CH; k >= 1; k--) begin
      cand     = (int'(last_grant_reg) + k) % N_CH;
      cand_idx = SEL_W'(cand);
      if (in_valid[cand_idx]) begin
        rr_found = 1'b1;
        rr_idx   = cand_idx;
      end
    end
  end

  // Forced select: an out-of-range sel simply never grants
  always_comb begin
    fs_found = (int'(sel) < N_CH) && in_valid[sel];
  end

  // Pick the grant for the current mode; reset suppresses every grant
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    if (!rst) begin
      if (mode) begin
        grant_found = fs_found;
        grant_idx   = sel;
      end else begin
        grant_found = rr_found;
        grant_idx   = rr_idx;
      end
    end
  end

  // A grant always targets a valid channel, so a grant with room is a transfer
  assign xfer = grant_found & load_en;

  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ready
      assign in_ready[gi] = xfer & (grant_idx == SEL_W'(gi));
    end
  endgenerate

  // Next-state for the output register and the round-robin pointer
  always_comb begin
    out_valid_next  = out_valid_reg;
    out_data_next   = out_data_reg;
    out_ch_next     = out_ch_reg;
    last_grant_next = last_grant_reg;
    if (xfer) begin
      out_valid_next = 1'b1;
      out_data_next  = ch_data[grant_idx];
      out_ch_next    = grant_idx;
      if (!mode) begin
        last_grant_next = grant_idx;
      end
    end else if (out_ready) begin
      out_valid_next = 1'b0;
    end
  end

  // State registers; reset parks the pointer so channel 0 is granted first
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_ch_reg     <= '0;
      last_grant_reg <= SEL_W'(N_CH - 1);
    end else begin
      out_valid_reg  <= out_valid_next;
      out_data_reg   <= out_data_next;
      out_ch_reg     <= out_ch_next;
      last_grant_reg <= last_grant_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_ch    = out_ch_reg;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr (N_CH=4, DATA_W=8). Each step drives
// inputs on the falling edge, checks in_ready against the expected grant,
// and checks the output register against a scoreboard of accepted words.
module tb_stream_mux_rr;

  localparam int N_CH   = 4;
  localparam int DATA_W = 8;
  localparam int SEL_W  = 2;

  logic                   clk;
  logic                   rst;
  logic                   mode;
  logic [SEL_W-1:0]       sel;
  logic [N_CH-1:0]        in_valid;
  logic [N_CH*DATA_W-1:0] in_data;
  logic [N_CH-1:0]        in_ready;
  logic                   out_valid;
  logic [DATA_W-1:0]      out_data;
  logic [SEL_W-1:0]       out_ch;
  logic                   out_ready;

  int n_assert = 0;
  int n_fail   = 0;

  logic [SEL_W+DATA_W-1:0] sb_q[$];
  logic                    exp_ov;

  stream_mux_rr #(.N_CH(N_CH), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3);
    in_data = {d3, d2, d1, d0};
  endtask

  // One clock step: inputs already driven; check, update scoreboard, advance
  task automatic do_cycle(input logic [N_CH-1:0] exp_ready, input string tag);
    logic [N_CH-1:0] acc;
    int              idx;
    #1;
    chk(32'(in_ready), 32'(exp_ready), {tag, " in_ready"});
    chk(32'(out_valid), 32'(exp_ov), {tag, " out_valid"});
    if (exp_ov) begin
      n_assert++;
      assert (sb_q.size() != 0) else begin
        n_fail++;
        $error("FAIL %s scoreboard: observed empty expected entry", tag);
      end
      if (sb_q.size() != 0)
        chk(32'({out_ch, out_data}), 32'(sb_q[0]), {tag, " out_ch/out_data"});
    end
    acc = exp_ready & in_valid;
    idx = -1;
    for (int i = 0; i < N_CH; i++) if (acc[i]) idx = i;
    if (exp_ov && out_ready && sb_q.size() != 0) void'(sb_q.pop_front());
    if (rst) begin
      sb_q.delete();
      exp_ov = 1'b0;
    end else if (idx >= 0) begin
      sb_q.push_back({SEL_W'(idx), in_data[idx*DATA_W +: DATA_W]});
      exp_ov = 1'b1;
      $display("[%0t] %s: accept ch %0d data %02h", $time, tag, idx, in_data[idx*DATA_W +: DATA_W]);
    end else if (out_ready) begin
      exp_ov = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    #1;
    chk(32'(out_valid), 32'd0, {tag, " out_valid"});
    chk(32'(out_data), 32'd0, {tag, " out_data"});
    chk(32'(out_ch), 32'd0, {tag, " out_ch"});
    chk(32'(in_ready), 32'd0, {tag, " in_ready"});
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; sel = '0; in_valid = 4'b1111; out_ready = 1'b1;
    set_data(8'hC0, 8'hC1, 8'hC2, 8'hC3);
    exp_ov = 1'b0;

    // Power-on reset, inputs active: nothing may be accepted
    @(negedge clk);
    #1;
    chk(32'(in_ready), 32'd0, "reset in_ready");
    @(negedge clk);
    check_reset_state("reset");

    // Round-robin over all four channels
    rst = 1'b0;
    do_cycle(4'b0001, "rr_all");
    do_cycle(4'b0010, "rr_all");
    do_cycle(4'b0100, "rr_all");
    do_cycle(4'b1000, "rr_all");
    do_cycle(4'b0001, "rr_all");

    // Sparse valid: only channels 1 and 3 alternate
    in_valid = 4'b1010;
    set_data(8'hB0, 8'hA1, 8'hB2, 8'hA3);
    do_cycle(4'b0010, "rr_sparse");
    do_cycle(4'b1000, "rr_sparse");
    do_cycle(4'b0010, "rr_sparse");

    // Backpressure: word 5C held three cycles, then one word per cycle
    in_valid = 4'b1111;
    set_data(8'h50, 8'h51, 8'h5C, 8'h53);
    do_cycle(4'b0100, "bp_load");
    out_ready = 1'b0;
    do_cycle(4'b0000, "bp_hold");
    do_cycle(4'b0000, "bp_hold");
    do_cycle(4'b0000, "bp_hold");
    out_ready = 1'b1;
    do_cycle(4'b1000, "bp_resume");
    do_cycle(4'b0001, "bp_resume");

    // Set pointer to channel 1
    in_valid = 4'b0010;
    do_cycle(4'b0010, "rr_ptr1");

    // Forced select channel 2 with every channel valid
    mode = 1'b1; sel = 2'd2; in_valid = 4'b1111;
    set_data(8'h20, 8'h21, 8'h22, 8'h23);
    do_cycle(4'b0100, "forced");
    do_cycle(4'b0100, "forced");
    do_cycle(4'b0100, "forced");
    in_valid = 4'b0000;
    do_cycle(4'b0000, "no_valid");
    sel = 2'd0; in_valid = 4'b0010;
    do_cycle(4'b0000, "forced_other");

    // Back to round-robin: resumes after channel 1
    mode = 1'b0; in_valid = 4'b1111;
    do_cycle(4'b0100, "rr_resume");
    do_cycle(4'b1000, "rr_resume");
    in_valid = 4'b0000;
    do_cycle(4'b0000, "drain");

    // Reset while a word is held under backpressure
    in_valid = 4'b1111;
    set_data(8'h90, 8'h91, 8'h92, 8'h93);
    do_cycle(4'b0001, "mid_load");
    out_ready = 1'b0;
    do_cycle(4'b0000, "mid_hold");
    rst = 1'b1;
    do_cycle(4'b0000, "mid_rst");
    check_reset_state("mid_rst_state");
    out_ready = 1'b1;
    do_cycle(4'b0000, "mid_rst2");
    rst = 1'b0;
    do_cycle(4'b0001, "post_rst");
    do_cycle(4'b0010, "post_rst");
    in_valid = 4'b0000;
    do_cycle(4'b0000, "final_drain");
    do_cycle(4'b0000, "final_drain");
    chk(32'(sb_q.size()), 32'd0, "scoreboard_empty");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
